// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU behind a valid/ready handshake.
// Multiply is shift-add and divide is restoring, one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative,
  output logic             DivByZero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SLT = 4'h8;
  localparam logic [3:0] OP_MSB = 4'h9;
  localparam logic [3:0] OP_REM = 4'hA;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] imm_res;
  logic             imm_carry, imm_ovf;
  logic             imm_dbz, imm_iter, b_zero;

  always_comb begin
    add_w     = {1'b0, A} + {1'b0, B};
    sub_w     = {1'b0, A} + {1'b0, ~B}
              + {{WIDTH{1'b0}}, 1'b1};
    b_zero    = (B == '0);
    imm_res   = '0;
    imm_carry = 1'b0;
    imm_ovf   = 1'b0;
    imm_dbz   = 1'b0;
    imm_iter  = 1'b0;
    unique case (ALUControl)
      OP_ADD: begin
        imm_res   = add_w[WIDTH-1:0];
        imm_carry = add_w[WIDTH];
        imm_ovf   = (A[WIDTH-1] == B[WIDTH-1])
                 && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        imm_res   = sub_w[WIDTH-1:0];
        imm_carry = sub_w[WIDTH];
        imm_ovf   = (A[WIDTH-1] != B[WIDTH-1])
                 && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: imm_res = A & B;
      OP_OR:  imm_res = A | B;
      // multiply by zero needs no iteration: product is 0
      OP_MUL: imm_iter = !b_zero;
      OP_DIV: begin
        if (b_zero) begin
          imm_res = '1;
          imm_dbz = 1'b1;
        end else begin
          imm_iter = 1'b1;
        end
      end
      OP_REM: begin
        if (b_zero) begin
          imm_res = A;
          imm_dbz = 1'b1;
        end else begin
          imm_iter = 1'b1;
        end
      end
      OP_SRL: imm_res = A >> 1;
      OP_SLL: imm_res = A << 1;
      OP_SLT: imm_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MSB: imm_res = {{(WIDTH-1){1'b0}}, add_w[WIDTH-1]};
      default: ;
    endcase
  end

  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum, div_shl, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // hi:lo is the running product (MUL) or remainder:quotient (DIV/REM)
  always_comb begin
    mul_add  = lo_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, hi_q} + {1'b0, mul_add};
    div_shl  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, opnd_q};
    div_ge   = ~div_diff[WIDTH];
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff[WIDTH-1:0]
                       : div_shl[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  logic [WIDTH-1:0] fin_res;
  logic             fin_carry;

  always_comb begin
    fin_res   = step_lo;
    fin_carry = 1'b0;
    unique case (1'b1)
      op_q == OP_MUL: fin_carry = |step_hi;
      op_q == OP_REM: fin_res   = step_hi;
      default: ;
    endcase
  end

  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_carry, wr_ovf, wr_dbz;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    wr_en    = 1'b0;
    wr_res   = '0;
    wr_carry = 1'b0;
    wr_ovf   = 1'b0;
    wr_dbz   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = ALUControl;
          opnd_d = (ALUControl == OP_MUL) ? A : B;
          hi_d   = '0;
          lo_d   = (ALUControl == OP_MUL) ? B : A;
          cnt_d  = '0;
          if (imm_iter) begin
            state_d = S_BUSY;
          end else begin
            wr_en    = 1'b1;
            wr_res   = imm_res;
            wr_carry = imm_carry;
            wr_ovf   = imm_ovf;
            wr_dbz   = imm_dbz;
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          wr_en    = 1'b1;
          wr_res   = fin_res;
          wr_carry = fin_carry;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    dbz_d   = dbz_q;
    if (wr_en) begin
      res_d   = wr_res;
      carry_d = wr_carry;
      ovf_d   = wr_ovf;
      zero_d  = (wr_res == '0);
      neg_d   = wr_res[WIDTH-1];
      dbz_d   = wr_dbz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Result    = res_q;
  assign Carry     = carry_q;
  assign OverFlow  = ovf_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign DivByZero = dbz_q;

endmodule
